// File: rtl/packet_cutter_ctrl.sv
// Converts snap-length requests into packet_cutter cut_* settings and applies them only at a packet boundary.
// Optional macro PACKET_CUTTER_CTRL_STATS_EN adds stat_cfg_applied / stat_pkts_held counters.
module packet_cutter_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH  = 32,
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int MIN_CUT_BYTES       = 64,
  parameter int MAX_CUT_BYTES       = 9600
) (
  input  logic                          axi_aclk,
  input  logic                          axi_reset,
  input  logic                          cfg_wr,
  input  logic                          cfg_cut_en,
  input  logic [15:0]                   cfg_cut_bytes,
  output logic                          cfg_busy,
  output logic                          cfg_ack,
  output logic                          cfg_err,
  input  logic                          mon_tvalid,
  input  logic                          mon_tready,
  input  logic                          mon_tlast,
  output logic                          cut_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_words,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_offset,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_bytes
`ifdef PACKET_CUTTER_CTRL_STATS_EN
  ,
  output logic [31:0]                   stat_cfg_applied,
  output logic [15:0]                   stat_pkts_held
`endif
);

  localparam int BPW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int DW  = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CALC     = 2'd1,
    ST_WAIT_BND = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_in_pkt;
  logic          w_in_pkt_nxt;
  logic          w_boundary;
  logic          w_beat;

  logic          w_accept;
  logic          w_reject;
  logic          w_load;
  logic          w_clip;

  logic          r_req_en;
  logic [15:0]   r_req_bytes;

  logic [DW-1:0] r_sh_words;
  logic [DW-1:0] r_sh_offset;
  logic [DW-1:0] r_sh_bytes;

  logic [15:0]   w_len;
  logic [15:0]   w_nwords;
  logic [15:0]   w_valid;
  logic [15:0]   w_shamt;
  logic [BPW-1:0] w_mask;
  logic [DW-1:0] w_sh_words;
  logic [DW-1:0] w_sh_offset;
  logic [DW-1:0] w_sh_bytes;

  logic          r_cfg_busy;
  logic          r_cfg_ack;
  logic          r_cfg_err;
  logic          r_cut_en;
  logic [DW-1:0] r_cut_words;
  logic [DW-1:0] r_cut_offset;
  logic [DW-1:0] r_cut_bytes;

  function automatic logic [15:0] f_clamp(input logic [15:0] b);
    if (b < 16'(MIN_CUT_BYTES))
      return 16'(MIN_CUT_BYTES);
    else if (b > 16'(MAX_CUT_BYTES))
      return 16'(MAX_CUT_BYTES);
    else
      return b;
  endfunction

  // A tlast beat closes the packet in the same cycle, so that cycle is already a boundary.
  assign w_beat       = mon_tvalid & mon_tready;
  assign w_in_pkt_nxt = w_beat ? ~mon_tlast : r_in_pkt;
  assign w_boundary   = ~w_in_pkt_nxt;

  assign w_clip = (cfg_cut_bytes < 16'(MIN_CUT_BYTES)) || (cfg_cut_bytes > 16'(MAX_CUT_BYTES));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_wr) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        w_reject    = cfg_wr;
        w_state_nxt = ST_WAIT_BND;
      end
      ST_WAIT_BND: begin
        w_reject = cfg_wr;
        if (w_boundary) begin
          w_load      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Clamp guarantees at least two words, so nwords-2 cannot underflow and valid is 1..BPW.
  always_comb begin
    w_len       = f_clamp(r_req_bytes);
    w_nwords    = (w_len + 16'(BPW - 1)) / 16'(BPW);
    w_valid     = w_len - 16'(BPW) * (w_nwords - 16'd1);
    w_shamt     = 16'(BPW) - w_valid;
    w_mask      = {BPW{1'b1}} << w_shamt;
    w_sh_offset = '0;
    w_sh_offset[BPW-1:0] = w_mask;
    w_sh_words  = DW'(w_nwords - 16'd2);
    w_sh_bytes  = DW'(w_len);
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state      <= ST_IDLE;
      r_in_pkt     <= 1'b0;
      r_req_en     <= 1'b0;
      r_req_bytes  <= '0;
      r_sh_words   <= '0;
      r_sh_offset  <= '1;
      r_sh_bytes   <= '0;
      r_cfg_busy   <= 1'b0;
      r_cfg_ack    <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_cut_en     <= 1'b0;
      r_cut_words  <= '0;
      r_cut_offset <= '1;
      r_cut_bytes  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_pkt  <= w_in_pkt_nxt;
      r_cfg_ack <= w_load;
      // Clip error is flagged on acceptance so it is visible during CALC.
      r_cfg_err <= w_reject | (w_accept & w_clip);
      if (w_accept) begin
        r_req_en    <= cfg_cut_en;
        r_req_bytes <= cfg_cut_bytes;
        r_cfg_busy  <= 1'b1;
      end
      if (r_state == ST_CALC) begin
        r_sh_words  <= w_sh_words;
        r_sh_offset <= w_sh_offset;
        r_sh_bytes  <= w_sh_bytes;
      end
      if (w_load) begin
        r_cfg_busy   <= 1'b0;
        r_cut_en     <= r_req_en;
        r_cut_words  <= r_sh_words;
        r_cut_offset <= r_sh_offset;
        r_cut_bytes  <= r_sh_bytes;
      end
    end
  end

  assign cfg_busy   = r_cfg_busy;
  assign cfg_ack    = r_cfg_ack;
  assign cfg_err    = r_cfg_err;
  assign cut_en     = r_cut_en;
  assign cut_words  = r_cut_words;
  assign cut_offset = r_cut_offset;
  assign cut_bytes  = r_cut_bytes;

`ifdef PACKET_CUTTER_CTRL_STATS_EN
  logic [31:0] r_stat_applied;
  logic [15:0] r_stat_held;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_stat_applied <= '0;
      r_stat_held    <= '0;
    end else begin
      if (w_load)
        r_stat_applied <= r_stat_applied + 32'd1;
      if ((r_state == ST_WAIT_BND) && w_beat && mon_tlast)
        r_stat_held <= r_stat_held + 16'd1;
    end
  end

  assign stat_cfg_applied = r_stat_applied;
  assign stat_pkts_held   = r_stat_held;
`endif

endmodule

// File: tb/tb_packet_cutter_ctrl.sv
// Directed bench for packet_cutter_ctrl: reset, encoding, boundary hold, clamping, busy reject, reset abort.
module tb_packet_cutter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic        cfg_cut_en;
  logic [15:0] cfg_cut_bytes;
  logic        cfg_busy;
  logic        cfg_ack;
  logic        cfg_err;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic        cut_en;
  logic [31:0] cut_words;
  logic [31:0] cut_offset;
  logic [31:0] cut_bytes;
`ifdef PACKET_CUTTER_CTRL_STATS_EN
  logic [31:0] stat_cfg_applied;
  logic [15:0] stat_pkts_held;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  packet_cutter_ctrl dut (
    .axi_aclk      (clk),
    .axi_reset     (rst),
    .cfg_wr        (cfg_wr),
    .cfg_cut_en    (cfg_cut_en),
    .cfg_cut_bytes (cfg_cut_bytes),
    .cfg_busy      (cfg_busy),
    .cfg_ack       (cfg_ack),
    .cfg_err       (cfg_err),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tlast     (mon_tlast),
    .cut_en        (cut_en),
    .cut_words     (cut_words),
    .cut_offset    (cut_offset),
    .cut_bytes     (cut_bytes)
`ifdef PACKET_CUTTER_CTRL_STATS_EN
    ,
    .stat_cfg_applied (stat_cfg_applied),
    .stat_pkts_held   (stat_pkts_held)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_req(input logic en, input logic [15:0] bytes);
    cfg_wr        = 1'b1;
    cfg_cut_en    = en;
    cfg_cut_bytes = bytes;
    tick;
    cfg_wr        = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (!cfg_ack && n < 50) begin
      tick;
      n++;
    end
    chk(tag, 32'(cfg_ack), 32'd1);
  endtask

  task automatic drive_beat(input logic last);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = last;
  endtask

  task automatic stream_idle;
    mon_tvalid = 1'b0;
    mon_tready = 1'b1;
    mon_tlast  = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    cfg_wr        = 1'b0;
    cfg_cut_en    = 1'b0;
    cfg_cut_bytes = '0;
    stream_idle();
    repeat (3) tick;
    rst = 1'b0;
    tick;

    // T1 reset values
    chk("t1_cut_en",  32'(cut_en),   32'd0);
    chk("t1_words",   cut_words,     32'd0);
    chk("t1_offset",  cut_offset,    32'hFFFF_FFFF);
    chk("t1_bytes",   cut_bytes,     32'd0);
    chk("t1_busy",    32'(cfg_busy), 32'd0);
    chk("t1_ack",     32'(cfg_ack),  32'd0);

    // T2 idle stream, 100 bytes, ack exactly at t+3
    cfg_req(1'b1, 16'd100);
    chk("t2_busy",    32'(cfg_busy), 32'd1);
    chk("t2_ack_t1",  32'(cfg_ack),  32'd0);
    tick;
    chk("t2_err",     32'(cfg_err),  32'd0);
    chk("t2_ack_t2",  32'(cfg_ack),  32'd0);
    tick;
    chk("t2_ack_t3",  32'(cfg_ack),  32'd1);
    chk("t2_words",   cut_words,     32'd2);
    chk("t2_offset",  cut_offset,    32'hF000_0000);
    chk("t2_bytes",   cut_bytes,     32'd100);
    chk("t2_cut_en",  32'(cut_en),   32'd1);
    chk("t2_busy_clr", 32'(cfg_busy), 32'd0);
    tick;
    chk("t2_ack_pulse", 32'(cfg_ack), 32'd0);

    // T3 mid-packet request held until tlast, then back-to-back next packet
    drive_beat(1'b0);
    repeat (3) tick;
    stream_idle();
    cfg_req(1'b1, 16'd64);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t3_hold_bytes", cut_bytes, 32'd100);
      chk("t3_hold_ack",   32'(cfg_ack), 32'd0);
    end
    drive_beat(1'b1);
    #1;
    chk("t3_bytes_at_c", cut_bytes, 32'd100);
    tick;
    drive_beat(1'b0);
    chk("t3_ack",     32'(cfg_ack), 32'd1);
    chk("t3_words",   cut_words,    32'd0);
    chk("t3_offset",  cut_offset,   32'hFFFF_FFFF);
    chk("t3_bytes",   cut_bytes,    32'd64);
    tick;
    chk("t3_ack_pulse", 32'(cfg_ack), 32'd0);
    drive_beat(1'b1);
    tick;
    stream_idle();
    tick;

    // T4 clamping below and above
    cfg_req(1'b1, 16'd10);
    chk("t4_err_lo",  32'(cfg_err), 32'd1);
    wait_ack("t4_ack_lo");
    chk("t4_bytes_lo", cut_bytes, 32'd64);
    tick;
    cfg_req(1'b1, 16'd20000);
    chk("t4_err_hi",  32'(cfg_err), 32'd1);
    wait_ack("t4_ack_hi");
    chk("t4_bytes_hi",  cut_bytes,  32'd9600);
    chk("t4_words_hi",  cut_words,  32'd298);
    chk("t4_offset_hi", cut_offset, 32'hFFFF_FFFF);
    tick;

    // Disabled cut still applies its length
    cfg_req(1'b0, 16'd200);
    chk("en0_err",    32'(cfg_err), 32'd0);
    wait_ack("en0_ack");
    chk("en0_cut_en", 32'(cut_en),  32'd0);
    chk("en0_bytes",  cut_bytes,    32'd200);
    chk("en0_words",  cut_words,    32'd5);
    chk("en0_offset", cut_offset,   32'hFF00_0000);
    tick;

    // T5 second request while busy is rejected
    cfg_wr        = 1'b1;
    cfg_cut_en    = 1'b1;
    cfg_cut_bytes = 16'd100;
    tick;
    chk("t5_err_calc", 32'(cfg_err), 32'd0);
    cfg_cut_bytes = 16'd200;
    tick;
    cfg_wr = 1'b0;
    chk("t5_err_rej", 32'(cfg_err),  32'd1);
    chk("t5_busy",    32'(cfg_busy), 32'd1);
    tick;
    chk("t5_ack",     32'(cfg_ack),  32'd1);
    chk("t5_bytes",   cut_bytes,     32'd100);
    chk("t5_words",   cut_words,     32'd2);
    // Request in the ack cycle is accepted
    cfg_req(1'b1, 16'd64);
    chk("ackwr_busy", 32'(cfg_busy), 32'd1);
    chk("ackwr_err",  32'(cfg_err),  32'd0);
    tick;
    tick;
    chk("ackwr_ack",   32'(cfg_ack), 32'd1);
    chk("ackwr_bytes", cut_bytes,    32'd64);
    tick;

    // T6 reset during WAIT_BND
    drive_beat(1'b0);
    tick;
    stream_idle();
    cfg_req(1'b1, 16'd300);
    tick;
    tick;
    chk("t6_busy_pre", 32'(cfg_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_cut_en", 32'(cut_en),   32'd0);
    chk("t6_bytes",  cut_bytes,     32'd0);
    chk("t6_words",  cut_words,     32'd0);
    chk("t6_offset", cut_offset,    32'hFFFF_FFFF);
    chk("t6_busy",   32'(cfg_busy), 32'd0);
`ifdef PACKET_CUTTER_CTRL_STATS_EN
    chk("t6_stat_applied", stat_cfg_applied, 32'd0);
    chk("t6_stat_held",    32'(stat_pkts_held), 32'd0);
`endif
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t6_no_ack", 32'(cfg_ack), 32'd0);
    end
    // in_pkt was cleared, so an idle-stream request applies at t+3
    cfg_req(1'b1, 16'd100);
    tick;
    tick;
    chk("t6_post_ack",   32'(cfg_ack), 32'd1);
    chk("t6_post_bytes", cut_bytes,    32'd100);
`ifdef PACKET_CUTTER_CTRL_STATS_EN
    tick;
    chk("stat_applied", stat_cfg_applied, 32'd1);
    chk("stat_held",    32'(stat_pkts_held), 32'd0);
`endif
    tick;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
